// File: rtl/id_stage_if.sv
// Bundle of the decode stage's pipeline-facing signals: IF/ID, WB and EX/MEM in,
// fetch redirect and the ID/EX register out.
interface id_stage_if;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_next;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        ex_mem_reg_write;
  logic        ex_mem_mem_read;
  logic [4:0]  ex_mem_write_reg;
  logic [31:0] ex_mem_alu_result;
  logic        jump_taken;
  logic        branch_taken;
  logic [31:0] pc_jump;
  logic [31:0] pc_branch;
  logic        stall;
  logic        flush_if;
  logic        id_ex_reg_write;
  logic        id_ex_mem_to_reg;
  logic        id_ex_mem_read;
  logic        id_ex_mem_write;
  logic        id_ex_alu_src;
  logic [3:0]  id_ex_alu_op;
  logic [31:0] id_ex_rs_data;
  logic [31:0] id_ex_rt_data;
  logic [31:0] id_ex_imm;
  logic [4:0]  id_ex_rs;
  logic [4:0]  id_ex_rt;
  logic [4:0]  id_ex_write_reg;

  modport slave (
    input  if_id_instruction, if_id_pc_next,
    input  wb_reg_write, wb_write_reg, wb_write_data,
    input  ex_mem_reg_write, ex_mem_mem_read, ex_mem_write_reg, ex_mem_alu_result,
    output jump_taken, branch_taken, pc_jump, pc_branch, stall, flush_if,
    output id_ex_reg_write, id_ex_mem_to_reg, id_ex_mem_read, id_ex_mem_write,
    output id_ex_alu_src, id_ex_alu_op, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
    output id_ex_rs, id_ex_rt, id_ex_write_reg
  );

  modport master (
    output if_id_instruction, if_id_pc_next,
    output wb_reg_write, wb_write_reg, wb_write_data,
    output ex_mem_reg_write, ex_mem_mem_read, ex_mem_write_reg, ex_mem_alu_result,
    input  jump_taken, branch_taken, pc_jump, pc_branch, stall, flush_if,
    input  id_ex_reg_write, id_ex_mem_to_reg, id_ex_mem_read, id_ex_mem_write,
    input  id_ex_alu_src, id_ex_alu_op, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
    input  id_ex_rs, id_ex_rt, id_ex_write_reg
  );
endinterface

// File: rtl/id_stage.sv
// MIPS decode stage: register file with WB bypass, main decoder, branch/jump
// resolution, hazard detection and the ID/EX pipeline register.
module id_stage (
  input  logic clk,
  input  logic rst,
  id_stage_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4
  } alu_op_e;

  logic [31:0] regs [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;

  assign opcode = bus.if_id_instruction[31:26];
  assign rs     = bus.if_id_instruction[25:21];
  assign rt     = bus.if_id_instruction[20:16];
  assign rd     = bus.if_id_instruction[15:11];
  assign funct  = bus.if_id_instruction[5:0];
  assign imm16  = bus.if_id_instruction[15:0];

  logic    ex_valid, is_beq, is_bne, is_j, uses_rt, zero_ext;
  logic    dec_reg_write, dec_mem_to_reg, dec_mem_read, dec_mem_write, dec_alu_src;
  alu_op_e dec_alu_op;
  logic [4:0] dec_write_reg;

  // ex_valid marks instructions that actually travel down to EX; everything else is a bubble.
  always_comb begin
    ex_valid       = 1'b0;
    is_beq         = 1'b0;
    is_bne         = 1'b0;
    is_j           = 1'b0;
    uses_rt        = 1'b0;
    zero_ext       = 1'b0;
    dec_reg_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_alu_src    = 1'b0;
    dec_alu_op     = ALU_ADD;
    dec_write_reg  = 5'd0;
    case (opcode)
      OP_RTYPE: begin
        ex_valid = 1'b1;
        case (funct)
          6'h20:   dec_alu_op = ALU_ADD;
          6'h22:   dec_alu_op = ALU_SUB;
          6'h24:   dec_alu_op = ALU_AND;
          6'h25:   dec_alu_op = ALU_OR;
          6'h2A:   dec_alu_op = ALU_SLT;
          default: ex_valid = 1'b0;
        endcase
        if (ex_valid) begin
          uses_rt       = 1'b1;
          dec_reg_write = 1'b1;
          dec_write_reg = rd;
        end
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        ex_valid      = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_write_reg = rt;
        case (opcode)
          OP_SLTI: dec_alu_op = ALU_SLT;
          OP_ANDI: begin dec_alu_op = ALU_AND; zero_ext = 1'b1; end
          OP_ORI:  begin dec_alu_op = ALU_OR;  zero_ext = 1'b1; end
          default: dec_alu_op = ALU_ADD;
        endcase
      end
      OP_LW: begin
        ex_valid       = 1'b1;
        dec_reg_write  = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_mem_read   = 1'b1;
        dec_alu_src    = 1'b1;
        dec_write_reg  = rt;
      end
      OP_SW: begin
        ex_valid      = 1'b1;
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        uses_rt       = 1'b1;
      end
      OP_BEQ: begin is_beq = 1'b1; uses_rt = 1'b1; end
      OP_BNE: begin is_bne = 1'b1; uses_rt = 1'b1; end
      OP_J:   is_j = 1'b1;
      default: ;
    endcase
    if (dec_write_reg == 5'd0)
      dec_reg_write = 1'b0;
  end

  logic [31:0] rs_val, rt_val, br_a, br_b, imm_ext;

  assign rs_val = (rs == 5'd0) ? 32'd0 :
                  (bus.wb_reg_write && bus.wb_write_reg == rs) ? bus.wb_write_data : regs[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 :
                  (bus.wb_reg_write && bus.wb_write_reg == rt) ? bus.wb_write_data : regs[rt];

  // Only a non-load in EX/MEM has its result ready in time for the ID comparator.
  assign br_a = (bus.ex_mem_reg_write && !bus.ex_mem_mem_read && bus.ex_mem_write_reg == rs && rs != 5'd0)
                ? bus.ex_mem_alu_result : rs_val;
  assign br_b = (bus.ex_mem_reg_write && !bus.ex_mem_mem_read && bus.ex_mem_write_reg == rt && rt != 5'd0)
                ? bus.ex_mem_alu_result : rt_val;

  assign imm_ext = zero_ext ? {16'd0, imm16} : {{16{imm16[15]}}, imm16};

  logic load_use, branch_hazard, rs_busy, rt_busy;

  assign load_use = bus.id_ex_mem_read && bus.id_ex_write_reg != 5'd0 &&
                    (bus.id_ex_write_reg == rs || (uses_rt && bus.id_ex_write_reg == rt));

  assign rs_busy = rs != 5'd0 &&
                   ((bus.id_ex_reg_write && bus.id_ex_write_reg == rs) ||
                    (bus.ex_mem_reg_write && bus.ex_mem_mem_read && bus.ex_mem_write_reg == rs));
  assign rt_busy = rt != 5'd0 &&
                   ((bus.id_ex_reg_write && bus.id_ex_write_reg == rt) ||
                    (bus.ex_mem_reg_write && bus.ex_mem_mem_read && bus.ex_mem_write_reg == rt));
  assign branch_hazard = (is_beq || is_bne) && (rs_busy || rt_busy);

  assign bus.stall        = load_use || branch_hazard;
  assign bus.branch_taken = !bus.stall && ((is_beq && br_a == br_b) || (is_bne && br_a != br_b));
  assign bus.jump_taken   = !bus.stall && is_j;
  assign bus.flush_if     = bus.branch_taken || bus.jump_taken;
  assign bus.pc_branch    = bus.if_id_pc_next + {{14{imm16[15]}}, imm16, 2'b00};
  assign bus.pc_jump      = {bus.if_id_pc_next[31:28], bus.if_id_instruction[25:0], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= 32'd0;
    end else if (bus.wb_reg_write && bus.wb_write_reg != 5'd0) begin
      regs[bus.wb_write_reg] <= bus.wb_write_data;
    end
  end

  // Stalls, branches, jumps and undecodable words all leave a bubble in ID/EX.
  always_ff @(posedge clk) begin
    if (rst || bus.stall || !ex_valid) begin
      bus.id_ex_reg_write  <= 1'b0;
      bus.id_ex_mem_to_reg <= 1'b0;
      bus.id_ex_mem_read   <= 1'b0;
      bus.id_ex_mem_write  <= 1'b0;
      bus.id_ex_alu_src    <= 1'b0;
      bus.id_ex_alu_op     <= 4'd0;
      bus.id_ex_rs_data    <= 32'd0;
      bus.id_ex_rt_data    <= 32'd0;
      bus.id_ex_imm        <= 32'd0;
      bus.id_ex_rs         <= 5'd0;
      bus.id_ex_rt         <= 5'd0;
      bus.id_ex_write_reg  <= 5'd0;
    end else begin
      bus.id_ex_reg_write  <= dec_reg_write;
      bus.id_ex_mem_to_reg <= dec_mem_to_reg;
      bus.id_ex_mem_read   <= dec_mem_read;
      bus.id_ex_mem_write  <= dec_mem_write;
      bus.id_ex_alu_src    <= dec_alu_src;
      bus.id_ex_alu_op     <= dec_alu_op;
      bus.id_ex_rs_data    <= rs_val;
      bus.id_ex_rt_data    <= rt_val;
      bus.id_ex_imm        <= imm_ext;
      bus.id_ex_rs         <= rs;
      bus.id_ex_rt         <= rt;
      bus.id_ex_write_reg  <= dec_write_reg;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Randomized self-checking bench for id_stage against an instruction-level
// reference model of the decode stage.
module tb_id_stage;

  logic clk = 1'b0;
  logic rst;

  id_stage_if bus ();

  id_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] mregs [32];
  logic        eRw, eM2r, eMr, eMw, eSrc;
  logic [3:0]  eOp;
  logic [31:0] eRsd, eRtd, eImm;
  logic [4:0]  eRs, eRt, eWr;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  function automatic logic [31:0] readModel(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (bus.wb_reg_write && bus.wb_write_reg == idx) return bus.wb_write_data;
    return mregs[idx];
  endfunction

  function automatic void clearModel();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    {eRw, eM2r, eMr, eMw, eSrc} = 5'd0;
    eOp = 4'd0; eRsd = 32'd0; eRtd = 32'd0; eImm = 32'd0;
    eRs = 5'd0; eRt = 5'd0; eWr = 5'd0;
  endfunction

  // One pipeline cycle: drive, check the combinational redirect, clock, check ID/EX.
  task automatic applyStimulus(input logic r, input logic [31:0] instr, input logic [31:0] pcn,
                               input logic wbWe, input logic [4:0] wbReg, input logic [31:0] wbData,
                               input logic emRw, input logic emMr, input logic [4:0] emReg,
                               input logic [31:0] emAlu);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, wr;
    logic [15:0] i16;
    logic        ok, rw, m2r, mr, mw, src, zx, useRt, isBeq, isBne, isJ;
    logic [3:0]  aluOp;
    logic [31:0] a, b;
    logic        loadUse, brHaz, st, bt, jt;
    logic        nRw, nM2r, nMr, nMw, nSrc;
    logic [3:0]  nOp;
    logic [31:0] nRsd, nRtd, nImm;
    logic [4:0]  nRs, nRt, nWr;

    @(negedge clk);
    rst = r;
    bus.if_id_instruction = instr;
    bus.if_id_pc_next     = pcn;
    bus.wb_reg_write      = wbWe;
    bus.wb_write_reg      = wbReg;
    bus.wb_write_data     = wbData;
    bus.ex_mem_reg_write  = emRw;
    bus.ex_mem_mem_read   = emMr;
    bus.ex_mem_write_reg  = emReg;
    bus.ex_mem_alu_result = emAlu;
    #1;

    op = instr[31:26]; fn = instr[5:0];
    rs = instr[25:21]; rt = instr[20:16]; rd = instr[15:11]; i16 = instr[15:0];
    {ok, rw, m2r, mr, mw, src, zx, useRt, isBeq, isBne, isJ} = 11'd0;
    aluOp = 4'd0; wr = 5'd0;
    case (op)
      6'h00: begin
        ok = 1'b1;
        if (fn == 6'h20) aluOp = 4'd0;
        else if (fn == 6'h22) aluOp = 4'd1;
        else if (fn == 6'h24) aluOp = 4'd2;
        else if (fn == 6'h25) aluOp = 4'd3;
        else if (fn == 6'h2A) aluOp = 4'd4;
        else ok = 1'b0;
        if (ok) begin rw = 1'b1; wr = rd; useRt = 1'b1; end
      end
      6'h08: begin ok = 1'b1; rw = 1'b1; src = 1'b1; wr = rt; aluOp = 4'd0; end
      6'h0A: begin ok = 1'b1; rw = 1'b1; src = 1'b1; wr = rt; aluOp = 4'd4; end
      6'h0C: begin ok = 1'b1; rw = 1'b1; src = 1'b1; wr = rt; aluOp = 4'd2; zx = 1'b1; end
      6'h0D: begin ok = 1'b1; rw = 1'b1; src = 1'b1; wr = rt; aluOp = 4'd3; zx = 1'b1; end
      6'h23: begin ok = 1'b1; rw = 1'b1; m2r = 1'b1; mr = 1'b1; src = 1'b1; wr = rt; end
      6'h2B: begin ok = 1'b1; mw = 1'b1; src = 1'b1; useRt = 1'b1; end
      6'h04: begin isBeq = 1'b1; useRt = 1'b1; end
      6'h05: begin isBne = 1'b1; useRt = 1'b1; end
      6'h02: isJ = 1'b1;
      default: ;
    endcase
    if (wr == 5'd0) rw = 1'b0;

    a = (emRw && !emMr && emReg == rs && rs != 0) ? emAlu : readModel(rs);
    b = (emRw && !emMr && emReg == rt && rt != 0) ? emAlu : readModel(rt);
    loadUse = eMr && eWr != 0 && (eWr == rs || (useRt && eWr == rt));
    brHaz = (isBeq || isBne) &&
            ((rs != 0 && ((eRw && eWr == rs) || (emRw && emMr && emReg == rs))) ||
             (rt != 0 && ((eRw && eWr == rt) || (emRw && emMr && emReg == rt))));
    st = loadUse || brHaz;
    bt = !st && ((isBeq && a == b) || (isBne && a != b));
    jt = !st && isJ;

    checkOutput("redirect{jt,bt,stall,flush}", {28'd0, bus.jump_taken, bus.branch_taken, bus.stall, bus.flush_if},
                {28'd0, jt, bt, st, bt | jt});
    checkOutput("pc_branch", bus.pc_branch, pcn + {{14{i16[15]}}, i16, 2'b00});
    checkOutput("pc_jump", bus.pc_jump, {pcn[31:28], instr[25:0], 2'b00});

    if (r || st || !ok) begin
      {nRw, nM2r, nMr, nMw, nSrc} = 5'd0;
      nOp = 4'd0; nRsd = 32'd0; nRtd = 32'd0; nImm = 32'd0; nRs = 5'd0; nRt = 5'd0; nWr = 5'd0;
    end else begin
      {nRw, nM2r, nMr, nMw, nSrc} = {rw, m2r, mr, mw, src};
      nOp = aluOp; nRsd = readModel(rs); nRtd = readModel(rt);
      nImm = zx ? {16'd0, i16} : {{16{i16[15]}}, i16};
      nRs = rs; nRt = rt; nWr = wr;
    end

    @(posedge clk);
    if (r) begin
      clearModel();
    end else begin
      if (wbWe && wbReg != 0) mregs[wbReg] = wbData;
      {eRw, eM2r, eMr, eMw, eSrc} = {nRw, nM2r, nMr, nMw, nSrc};
      eOp = nOp; eRsd = nRsd; eRtd = nRtd; eImm = nImm; eRs = nRs; eRt = nRt; eWr = nWr;
    end
    #1;
    checkOutput("id_ex_ctrl", {23'd0, bus.id_ex_reg_write, bus.id_ex_mem_to_reg, bus.id_ex_mem_read,
                bus.id_ex_mem_write, bus.id_ex_alu_src, bus.id_ex_alu_op},
                {23'd0, eRw, eM2r, eMr, eMw, eSrc, eOp});
    checkOutput("id_ex_rs_data", bus.id_ex_rs_data, eRsd);
    checkOutput("id_ex_rt_data", bus.id_ex_rt_data, eRtd);
    checkOutput("id_ex_imm", bus.id_ex_imm, eImm);
    checkOutput("id_ex_idx", {17'd0, bus.id_ex_rs, bus.id_ex_rt, bus.id_ex_write_reg}, {17'd0, eRs, eRt, eWr});
  endtask

  function automatic logic [31:0] randInstr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] i16;
    logic [5:0]  functs [5];
    logic [5:0]  iops [6];
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    iops   = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B};
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    i16 = 16'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2: return {6'h00, rs, rt, rd, 5'd0, functs[$urandom_range(0, 4)]};
      3, 4, 5: return {iops[$urandom_range(0, 5)], rs, rt, i16};
      6:       return {6'h04, rs, rt, i16};
      7:       return {6'h05, rs, rt, i16};
      8:       return {6'h02, 26'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    bus.if_id_instruction = 32'd0;
    bus.if_id_pc_next     = 32'd0;
    bus.wb_reg_write      = 1'b0;
    bus.wb_write_reg      = 5'd0;
    bus.wb_write_data     = 32'd0;
    bus.ex_mem_reg_write  = 1'b0;
    bus.ex_mem_mem_read   = 1'b0;
    bus.ex_mem_write_reg  = 5'd0;
    bus.ex_mem_alu_result = 32'd0;
    clearModel();
    repeat (2) @(posedge clk);

    applyStimulus(1'b1, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);

    // addi r1,r0,5 while WB writes r1=5
    applyStimulus(1'b0, 32'h20010005, 32'h4, 1'b1, 5'd1, 32'd5, 1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("tp_addi_imm", bus.id_ex_imm, 32'd5);
    checkOutput("tp_addi_wr", {27'd0, bus.id_ex_write_reg}, 32'd1);

    // add r3,r2,r2 with WB bypass of r2
    applyStimulus(1'b0, 32'h00421820, 32'h8, 1'b1, 5'd2, 32'h1234, 1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("tp_bypass_rs", bus.id_ex_rs_data, 32'h1234);
    checkOutput("tp_bypass_rt", bus.id_ex_rt_data, 32'h1234);

    // lw r4,0(r0) then add r5,r4,r1: one stall cycle, then the add latches
    applyStimulus(1'b0, 32'h8C040000, 32'hC, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b0, 32'h00812820, 32'h10, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("tp_loaduse_bubble", {31'd0, bus.id_ex_reg_write}, 32'd0);
    applyStimulus(1'b0, 32'h00812820, 32'h10, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("tp_loaduse_wr", {27'd0, bus.id_ex_write_reg}, 32'd5);

    // beq r1,r1,+3 at pc+4=0x20
    applyStimulus(1'b0, 32'h10210003, 32'h20, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("tp_pc_branch", bus.pc_branch, 32'h2C);

    // bne r6,r0: forwarded non-load, then a load to r6 stalls it
    applyStimulus(1'b0, 32'h14C00004, 32'h30, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd6, 32'd7);
    applyStimulus(1'b0, 32'h14C00004, 32'h30, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd6, 32'd7);

    // j 0x10 at pc+4=0x40
    applyStimulus(1'b0, 32'h08000010, 32'h40, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("tp_pc_jump", bus.pc_jump, 32'h40);

    // reset asserted during a load-use stall, then r1 must read 0
    applyStimulus(1'b0, 32'h8C040000, 32'h44, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 32'h00812820, 32'h48, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b0, 32'h00203820, 32'h4C, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    checkOutput("tp_reset_r1", bus.id_ex_rs_data, 32'd0);

    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 59) == 0), randInstr(), $urandom & 32'hFFFF_FFFC,
                    1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 5-stage MIPS pipeline. It consumes the IF/ID register (instruction, pc+4).
- Contains the 32x32 register file, with writeback bypass, and the main decoder.
- Resolves branches and jumps in ID, and drives the redirect, stall and flush signals back to the fetch stage.
- Detects load-use and branch-operand hazards and registers decoded controls and operands into the ID/EX register.

Parameters:
none; all widths are fixed by MIPS32 (32-bit data, 5-bit register index).

Ports:
clk  in  1  clock
rst  in  1  one clock; reset is synchronous and active-high
if_id_instruction  in  32  instruction from fetch
if_id_pc_next  in  32  pc+4 of that instruction
wb_reg_write  in  1  writeback enable
wb_write_reg  in  5  writeback destination
wb_write_data  in  32  writeback data
ex_mem_reg_write  in  1  EX/MEM writes a register
ex_mem_mem_read  in  1  EX/MEM is a load
ex_mem_write_reg  in  5  EX/MEM destination
ex_mem_alu_result  in  32  EX/MEM ALU result (branch forwarding)
jump_taken  out  1  j in ID, comb
branch_taken  out  1  beq/bne taken, comb
pc_jump  out  32  jump target, comb
pc_branch  out  32  branch target, comb
stall  out  1  hold PC and IF/ID, comb
flush_if  out  1  squash IF/ID, comb
id_ex_reg_write, id_ex_mem_to_reg, id_ex_mem_read, id_ex_mem_write, id_ex_alu_src  out  1 each  registered controls
id_ex_alu_op  out  4  0 add, 1 sub, 2 and, 3 or, 4 slt
id_ex_rs_data, id_ex_rt_data, id_ex_imm  out  32 each  operands; imm sign-extended, or zero-extended for andi/ori
id_ex_rs, id_ex_rt, id_ex_write_reg  out  5 each  register indices

Behaviour:
- Decoded subset:
  - R-type (funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt); addi, andi, ori, slti; lw, sw; beq, bne; j.
  - Any other opcode/funct, and instruction 0, decode as a bubble (all controls 0).
- write_reg:
  - rd for R-type; rt for I-type ALU ops and lw.
  - A write_reg of 0 forces reg_write=0.
- Register file:
  - Write on posedge clk when wb_reg_write and wb_write_reg!=0.
  - Reads are combinational.
  - A same-cycle write to the register being read bypasses wb_write_data.
  - r0 always reads 0.
- Load-use hazard:
  - Condition: id_ex_mem_read && id_ex_write_reg!=0 && (id_ex_write_reg==rs || (uses_rt && id_ex_write_reg==rt)).
  - uses_rt is set for R-type, sw, beq, bne.
- Branch hazard (beq/bne only):
  - Stall if id_ex_reg_write matches a nonzero rs/rt.
  - Stall if ex_mem_reg_write && ex_mem_mem_read matches a nonzero rs/rt.
  - If ex_mem_reg_write && !ex_mem_mem_read matches, forward ex_mem_alu_result.
- Branch operand priority: EX/MEM forward > WB bypass > register file.
- stall = load_use | branch_hazard.
- Redirect outputs:
  - branch_taken = !stall && ((beq && a==b) || (bne && a!=b)).
  - jump_taken = !stall && j.
  - flush_if = branch_taken | jump_taken.
- Targets:
  - pc_branch = if_id_pc_next + (sext(imm16)<<2), mod 2^32.
  - pc_jump = {if_id_pc_next[31:28], instr[25:0], 2'b00}.
  - Both are driven regardless of taken.
- ID/EX register (posedge clk):
  - rst: all ID/EX outputs and all 32 registers are cleared to 0.
  - else if stall: ID/EX loads a bubble (all outputs 0). Fetch holds IF/ID, so the instruction re-decodes next cycle.
  - else: ID/EX loads the decoded values. Branches and jumps enter as bubbles (no write, no memory access).
- Latency:
  - Decode to ID/EX outputs: 1 cycle.
  - Redirect: same cycle. The fetch stage applies it at the next edge and squashes the one fetched slot.
- A reset in mid-stall takes priority: ID/EX is cleared and the regfile is zeroed.

Test Plan:
- addi r1,r0,5 (0x20010005) after reset -> next edge: id_ex_reg_write=1, id_ex_alu_src=1, alu_op=0, imm=5, write_reg=1, rs_data=0; stall=0.
- WB writes r2=0x1234 while ID reads add r3,r2,r2 -> id_ex_rs_data = id_ex_rt_data = 0x1234 (bypass).
- lw r4,0(r0) in ID/EX, then add r5,r4,r1 in ID -> stall=1 for exactly 1 cycle, bubble in ID/EX; the following edge latches the add with write_reg=5.
- beq r1,r1,+3 with if_id_pc_next=0x20, no hazards -> branch_taken=1, pc_branch=0x2C, flush_if=1; ID/EX gets a bubble.
- bne r6,r0 with EX/MEM non-load writing r6=7 -> forwarded, branch_taken=1. If EX/MEM is instead a load to r6 -> stall=1, branch_taken=0.
- j 0x0000010 with if_id_pc_next=0x40 -> jump_taken=1, pc_jump=0x40. Assert rst during a stall -> all id_ex outputs 0 next edge, and r1 then reads 0.
